// File: rtl/secure_mem_pkg.sv
// ---------------------------------------------------------------------------
// secure_mem_pkg
//   Shared types and default sizes for the secure memory write path.
//   - state_e    : controller state, SCRUB (zeroizing) or LOAD (accepting data)
//   - DEPTH_DEF  : default number of memory entries (power of two)
//   - DATA_W_DEF : default byte / memory word width
// ---------------------------------------------------------------------------
package secure_mem_pkg;

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    LOAD  = 1'b1
  } state_e;

  localparam int DEPTH_DEF  = 16;
  localparam int DATA_W_DEF = 8;

endpackage : secure_mem_pkg

// File: rtl/secure_mem_write_ctrl_chk.sv
// ---------------------------------------------------------------------------
// secure_mem_write_ctrl_chk
//   Property checker for secure_mem_write_ctrl. It only observes the
//   controller's ports and holds no design logic.
//   Ports (all inputs):
//     clk, rst            clock and synchronous active-high reset
//     s_ready, busy       stream accept and scrub-in-progress flags
//     scrub_done          one-cycle end-of-scrub pulse
//     mem_we, mem_wdata   registered memory write strobe and data
//     fill                bytes written in the current session
// ---------------------------------------------------------------------------
module secure_mem_write_ctrl_chk
  import secure_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst,
  input logic              s_ready,
  input logic              busy,
  input logic              scrub_done,
  input logic              mem_we,
  input logic [DATA_W-1:0] mem_wdata,
  input logic [PTR_W:0]    fill
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  // The stream is never accepted while the memory is being zeroized.
  a_no_accept_in_scrub : assert property (@(posedge clk) disable iff (rst)
    !(s_ready && busy));

  // A full session never accepts another byte.
  a_no_accept_when_full : assert property (@(posedge clk) disable iff (rst)
    s_ready |-> (fill < DEPTH_C));

  // The fill count never exceeds the memory depth.
  a_fill_in_range : assert property (@(posedge clk) disable iff (rst)
    fill <= DEPTH_C);

  // Every scrub cycle issues a zero write on the following cycle.
  a_scrub_writes_zero : assert property (@(posedge clk) disable iff (rst)
    busy |=> (mem_we && (mem_wdata == '0)));

  // The completion pulse only appears once the controller is back in LOAD.
  a_done_after_scrub : assert property (@(posedge clk) disable iff (rst)
    scrub_done |-> !busy);

endmodule : secure_mem_write_ctrl_chk

// File: rtl/secure_mem_write_ctrl.sv
// ---------------------------------------------------------------------------
// secure_mem_write_ctrl
//   Upstream write controller for an auto-incrementing secure memory. It
//   accepts one valid/ready byte stream per session and forwards each byte as
//   a registered write. After reset and after each session ends, it zeroizes
//   every memory entry. It keeps writing zeros until the memory's internal
//   write pointer, which it shadows, is back at 0. This means every session
//   starts at address 0 and no data survives into the next session.
//
//   Ports:
//     clk          in   clock
//     rst          in   synchronous active-high reset (shared with memory)
//     s_valid      in   upstream byte valid
//     s_data       in   upstream byte
//     s_ready      out  accept; high only in LOAD with room left
//     session_end  in   one-cycle pulse: session released, start scrub
//     mem_we       out  memory write_enable (registered)
//     mem_wdata    out  memory data_in (registered)
//     wr_ptr       out  shadow of the memory write address
//     fill         out  bytes written in the current session, 0..DEPTH
//     busy         out  high while zeroizing
//     scrub_done   out  one-cycle pulse when zeroizing completes
// ---------------------------------------------------------------------------
module secure_mem_write_ctrl
  import secure_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              session_end,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W:0]    fill,
  output logic              busy,
  output logic              scrub_done
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1'b1);

  state_e              state_q,      state_d;
  logic                mem_we_q,     mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [PTR_W-1:0]    wr_ptr_q,     wr_ptr_d;
  logic [PTR_W:0]      fill_q,       fill_d;
  logic [PTR_W:0]      scrub_cnt_q,  scrub_cnt_d;
  logic                scrub_done_q, scrub_done_d;

  logic                handshake;
  logic [PTR_W:0]      scrub_cnt_inc;
  logic [PTR_W-1:0]    wr_ptr_inc;

  // s_ready depends only on registers, so upstream logic never sees a
  // combinational path from s_valid back to s_ready.
  assign s_ready    = (state_q == LOAD) && (fill_q < DEPTH_C);
  assign handshake  = s_valid && s_ready;
  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;

  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign wr_ptr     = wr_ptr_q;
  assign fill       = fill_q;
  assign busy       = (state_q == SCRUB);
  assign scrub_done = scrub_done_q;

  // Saturating scrub counter increment; it stops at DEPTH and does not wrap.
  always_comb begin
    scrub_cnt_inc = scrub_cnt_q;
    if (scrub_cnt_q < DEPTH_C) begin
      scrub_cnt_inc = scrub_cnt_q + CNT_ONE;
    end else begin
      scrub_cnt_inc = scrub_cnt_q;
    end
  end

  // Next-state and next-output logic for the SCRUB/LOAD controller.
  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    scrub_cnt_d  = scrub_cnt_q;
    scrub_done_d = 1'b0;

    case (state_q)
      SCRUB: begin
        // Zeroize one entry per cycle. At least DEPTH writes are needed to
        // cover every entry. After that, keep writing until the pointer
        // wraps to 0 so the next session starts at address 0.
        mem_we_d    = 1'b1;
        mem_wdata_d = '0;
        wr_ptr_d    = wr_ptr_inc;
        scrub_cnt_d = scrub_cnt_inc;
        if ((scrub_cnt_inc >= DEPTH_C) && (wr_ptr_inc == '0)) begin
          state_d      = LOAD;
          fill_d       = '0;
          scrub_cnt_d  = '0;
          scrub_done_d = 1'b1;
        end else begin
          state_d = SCRUB;
        end
      end

      LOAD: begin
        if (handshake) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = s_data;
          wr_ptr_d    = wr_ptr_inc;
          fill_d      = fill_q + CNT_ONE;
        end else begin
          mem_we_d    = 1'b0;
          mem_wdata_d = mem_wdata_q;
        end
        // A byte accepted alongside session_end is still written above. The
        // scrub that follows then erases it along with the rest.
        if (session_end) begin
          state_d = SCRUB;
        end else begin
          state_d = LOAD;
        end
      end

      default: begin
        // Unreachable encoding: fall back to zeroizing, the safe state.
        state_d     = SCRUB;
        scrub_cnt_d = '0;
      end
    endcase
  end

  // State and output registers. Reset restarts a full scrub from pointer 0,
  // matching the memory, which shares this reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCRUB;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      scrub_cnt_q  <= '0;
      scrub_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      scrub_cnt_q  <= scrub_cnt_d;
      scrub_done_q <= scrub_done_d;
    end
  end

endmodule : secure_mem_write_ctrl

// File: tb/tb_secure_mem_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_secure_mem_write_ctrl
//   Self-checking bench for secure_mem_write_ctrl. When stimulus is driven,
//   the expected memory writes are pushed into a scoreboard queue. A monitor
//   pops and compares them whenever mem_we is seen. A reference model of the
//   auto-incrementing memory tracks contents and the write pointer.
// ---------------------------------------------------------------------------
module tb_secure_mem_write_ctrl;
  import secure_mem_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int DP = DEPTH_DEF;
  localparam int PW = $clog2(DP);

  logic          clk         = 1'b0;
  logic          rst         = 1'b1;
  logic          s_valid     = 1'b0;
  logic [DW-1:0] s_data      = 8'h00;
  logic          session_end = 1'b0;
  logic          s_ready;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   fill;
  logic          busy;
  logic          scrub_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem[DP];
  int            ref_ptr = 0;
  int            exp_ptr = 0;

  always #5 clk = ~clk;

  secure_mem_write_ctrl #(.DATA_W(DW), .DEPTH(DP), .PTR_W(PW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .session_end(session_end), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .wr_ptr(wr_ptr), .fill(fill), .busy(busy), .scrub_done(scrub_done)
  );

  secure_mem_write_ctrl_chk #(.DATA_W(DW), .DEPTH(DP), .PTR_W(PW)) chk (
    .clk(clk), .rst(rst), .s_ready(s_ready), .busy(busy), .scrub_done(scrub_done),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .fill(fill)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the zero writes a scrub must issue from the expected pointer position.
  task automatic push_scrub();
    int n;
    n = DP + ((DP - exp_ptr) % DP);
    for (int i = 0; i < n; i++) exp_q.push_back(8'h00);
    exp_ptr = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; s_valid = 1'b0; session_end = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_mem_we",     32'(mem_we),     32'd0);
    check_val("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    check_val("rst_wr_ptr",     32'(wr_ptr),     32'd0);
    check_val("rst_fill",       32'(fill),       32'd0);
    check_val("rst_busy",       32'(busy),       32'd1);
    check_val("rst_scrub_done", 32'(scrub_done), 32'd0);
    check_val("rst_s_ready",    32'(s_ready),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ptr = 0;
    push_scrub();
  endtask

  // Offer n bytes starting at 'first'; stops after n accepts or 'budget' cycles.
  task automatic send_bytes(input logic [DW-1:0] first, input int n, input int budget,
                            output int acc);
    int            idx;
    bit            pend;
    bit            hs;
    logic [DW-1:0] pend_data;
    idx = 0; acc = 0; pend = 1'b0; pend_data = 8'h00;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < budget && idx < n; cyc++) begin
      s_valid = 1'b1;
      s_data  = first + 8'(idx);
      @(negedge clk);
      if (pend) begin
        check_val("lat_we",   32'(mem_we),    32'd1);
        check_val("lat_data", 32'(mem_wdata), 32'(pend_data));
      end else begin
        check_val("idle_we",  32'(mem_we),    32'd0);
      end
      hs = s_ready;
      @(posedge clk); #1;
      pend      = hs;
      pend_data = s_data;
      if (hs) begin
        exp_q.push_back(s_data);
        exp_ptr = (exp_ptr + 1) % DP;
        idx++;
        acc++;
      end
    end
    if (idx >= n) s_valid = 1'b0;
    if (pend) begin
      @(negedge clk);
      check_val("lat_we",   32'(mem_we),    32'd1);
      check_val("lat_data", 32'(mem_wdata), 32'(pend_data));
    end
  endtask

  task automatic end_session();
    @(posedge clk); #1;
    session_end = 1'b1;
    push_scrub();
    @(posedge clk); #1;
    session_end = 1'b0;
  endtask

  task automatic wait_scrub(input string tag);
    int cyc;
    bit seen;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (scrub_done === 1'b1) begin
        seen = 1'b1;
      end else if (cyc == 1) begin
        check_val($sformatf("%s_busy", tag), 32'(busy), 32'd1);
      end
    end
    check_val($sformatf("%s_done_seen", tag), 32'(seen),    32'd1);
    check_val($sformatf("%s_busy_low", tag),  32'(busy),    32'd0);
    check_val($sformatf("%s_ready", tag),     32'(s_ready), 32'd1);
    check_val($sformatf("%s_wr_ptr", tag),    32'(wr_ptr),  32'd0);
    check_val($sformatf("%s_fill", tag),      32'(fill),    32'd0);
    @(negedge clk);
    check_val($sformatf("%s_done_pulse", tag), 32'(scrub_done),    32'd0);
    check_val($sformatf("%s_sb_drained", tag), 32'(exp_q.size()), 32'd0);
    check_val($sformatf("%s_ref_ptr", tag),    32'(ref_ptr),       32'd0);
  endtask

  task automatic check_mem_zero(input string tag);
    logic [DW-1:0] acc_or;
    acc_or = 8'h00;
    for (int i = 0; i < DP; i++) acc_or = acc_or | ref_mem[i];
    check_val(tag, 32'(acc_or), 32'd0);
  endtask

  // Monitor: reference memory plus scoreboard pop on every observed write.
  initial begin : monitor
    logic [DW-1:0] want;
    forever begin
      @(negedge clk);
      if (rst) begin
        ref_ptr = 0;
        exp_q.delete();
      end else if (mem_we === 1'b1) begin
        check_val("sb_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check_val("sb_wdata", 32'(mem_wdata), 32'(want));
        end
        ref_mem[ref_ptr] = mem_wdata;
        ref_ptr = (ref_ptr + 1) % DP;
        check_val("ptr_shadow", 32'(wr_ptr), 32'(ref_ptr));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int acc;

    // 1: reset then the initial 16-write scrub
    apply_reset();
    wait_scrub("t1");
    check_mem_zero("t1_mem_zero");

    // 2: five back-to-back bytes
    send_bytes(8'hA1, 5, 20, acc);
    check_val("t2_acc",    32'(acc),    32'd5);
    check_val("t2_fill",   32'(fill),   32'd5);
    check_val("t2_wr_ptr", 32'(wr_ptr), 32'd5);
    @(negedge clk);
    for (int i = 0; i < 5; i++) check_val("t2_mem", 32'(ref_mem[i]), 32'(8'hA1 + 8'(i)));

    // 3: session end from pointer 5 -> 27 zero writes
    end_session();
    wait_scrub("t3");
    check_mem_zero("t3_mem_zero");

    // 4: twenty bytes offered, sixteen accepted, the rest stall
    send_bytes(8'h10, 20, 30, acc);
    check_val("t4_acc", 32'(acc), 32'd16);
    @(negedge clk);
    check_val("t4_stall_ready", 32'(s_ready), 32'd0);
    check_val("t4_fill_full",   32'(fill),    32'd16);
    check_val("t4_stall_we",    32'(mem_we),  32'd0);
    check_val("t4_wr_ptr",      32'(wr_ptr),  32'd0);
    check_val("t4_mem_first",   32'(ref_mem[0]),  32'h10);
    check_val("t4_mem_last",    32'(ref_mem[15]), 32'h1F);
    @(posedge clk); #1;
    s_valid = 1'b0;
    end_session();
    wait_scrub("t4");
    check_mem_zero("t4_mem_zero");

    // 5: handshake together with session_end at fill=3
    send_bytes(8'h30, 3, 10, acc);
    check_val("t5_acc", 32'(acc), 32'd3);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h5C; session_end = 1'b1;
    @(negedge clk);
    check_val("t5_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(8'h5C);
    exp_ptr = (exp_ptr + 1) % DP;
    push_scrub();
    s_valid = 1'b0; session_end = 1'b0;
    @(negedge clk);
    check_val("t5_we",    32'(mem_we),    32'd1);
    check_val("t5_data",  32'(mem_wdata), 32'h5C);
    check_val("t5_fill",  32'(fill),      32'd4);
    check_val("t5_busy",  32'(busy),      32'd1);
    wait_scrub("t5");
    check_mem_zero("t5_mem_zero");

    // 6: reset in the middle of a scrub, then session_end ignored in SCRUB
    send_bytes(8'h60, 2, 10, acc);
    end_session();
    @(negedge clk);
    check_val("t6_busy_pre", 32'(busy), 32'd1);
    repeat (5) @(posedge clk);
    apply_reset();
    repeat (3) @(posedge clk);
    #1 session_end = 1'b1;
    @(posedge clk); #1;
    session_end = 1'b0;
    wait_scrub("t6");
    repeat (4) @(negedge clk);
    check_val("t6_idle_busy", 32'(busy),         32'd0);
    check_val("t6_idle_we",   32'(mem_we),       32'd0);
    check_val("t6_sb_empty",  32'(exp_q.size()), 32'd0);
    check_mem_zero("t6_mem_zero");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_secure_mem_write_ctrl
